// File: rtl/seq_div_16_bit_if.sv
// seq_div_16_bit_if: start/operand request and result bundle of the 16-bit sequential divider
interface seq_div_16_bit_if;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] Q;
  logic [15:0] R;
  logic        Div_Zero;
  modport master (output start, A, B, input busy, done, Q, R, Div_Zero);
  modport slave  (input start, A, B, output busy, done, Q, R, Div_Zero);
endinterface

// File: rtl/seq_div_16_bit.sv
// seq_div_16_bit: 16-bit unsigned restoring divider, one quotient bit per cycle
module seq_div_16_bit (
  input  logic             clk,
  input  logic             rst_n,
  seq_div_16_bit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] dvd_q;
  logic [15:0] b_q;
  logic [15:0] rem_q;
  logic [15:0] q_q;
  logic [15:0] r_q;
  logic        busy_q;
  logic        done_q;
  logic        dz_q;
  logic [16:0] shift_d;
  logic [16:0] trial_d;
  logic [15:0] rem_d;
  logic [15:0] dvd_d;
  // One restoring step: a 17-bit trial so a remainder with bit 15 set cannot overflow.
  // Since rem_q < B holds, bit 16 of the trial is exactly the borrow.
  always_comb begin
    shift_d = {rem_q, dvd_q[15]};
    trial_d = shift_d - {1'b0, b_q};
    rem_d   = trial_d[16] ? shift_d[15:0] : trial_d[15:0];
    dvd_d   = {dvd_q[14:0], ~trial_d[16]};
  end
  // Control FSM with registered outputs; the dividend register fills with quotient bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          dvd_q  <= bus.A;
          b_q    <= bus.B;
          rem_q  <= '0;
          cnt_q  <= '0;
          busy_q <= 1'b1;
          if (bus.B == 16'd0) begin
            state_q <= DONE;
            q_q     <= 16'hFFFF;
            r_q     <= bus.A;
            dz_q    <= 1'b1;
            done_q  <= 1'b1;
          end else begin
            state_q <= RUN;
            dz_q    <= 1'b0;
          end
        end
        RUN: begin
          rem_q <= rem_d;
          dvd_q <= dvd_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_q <= DONE;
            q_q     <= dvd_d;
            r_q     <= rem_d;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.Q        = q_q;
  assign bus.R        = r_q;
  assign bus.Div_Zero = dz_q;
endmodule

// File: tb/tb_seq_div_16_bit.sv
// tb_seq_div_16_bit: directed and random checks of the 16-bit sequential divider
module tb_seq_div_16_bit;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  seq_div_16_bit_if bus ();
  seq_div_16_bit dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    check({tag, ".busy"}, 32'(bus.busy), 0);
    check({tag, ".done"}, 32'(bus.done), 0);
    check({tag, ".Q"}, 32'(bus.Q), 0);
    check({tag, ".R"}, 32'(bus.R), 0);
    check({tag, ".dz"}, 32'(bus.Div_Zero), 0);
  endtask
  // Launch one divide, optionally inject a stray start or a reset n cycles after acceptance.
  task automatic run(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input int inj_at, input int rst_at);
    logic [15:0] eq;
    logic [15:0] er;
    logic        edz;
    int          elat;
    int          lat;
    int          pulses;
    int          busy_bad;
    edz  = (b == 16'd0);
    eq   = edz ? 16'hFFFF : a / b;
    er   = edz ? a : a % b;
    elat = edz ? 1 : 17;
    @(negedge clk);
    bus.start = 1'b1;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A = ~a;
    bus.B = b ^ 16'h5a5a;
    lat = 0;
    pulses = 0;
    busy_bad = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == inj_at) begin
        bus.start = 1'b1;
        bus.A = 16'd50;
        bus.B = 16'd5;
      end
      if (n == inj_at + 1) bus.start = 1'b0;
      if (n == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_zero({tag, ".rst"});
      end
      if (n == rst_at + 2) rst_n = 1'b1;
      if (bus.done) begin
        pulses++;
        if (lat == 0) lat = n;
      end
      if (rst_at == 0 && bus.busy !== (lat == 0 || n == lat)) busy_bad++;
    end
    if (rst_at != 0) begin
      check({tag, ".pulses"}, pulses, 0);
    end else begin
      check({tag, ".lat"}, lat, elat);
      check({tag, ".pulses"}, pulses, 1);
      check({tag, ".busy"}, busy_bad, 0);
      check({tag, ".Q"}, 32'(bus.Q), 32'(eq));
      check({tag, ".R"}, 32'(bus.R), 32'(er));
      check({tag, ".dz"}, 32'(bus.Div_Zero), 32'(edz));
    end
  endtask
  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    run("d523", 16'd523, 16'd234, 0, 0);
    check("d523.q2", 32'(bus.Q), 2);
    run("d40535", 16'd40535, 16'd25000, 0, 0);
    check("d40535.r", 32'(bus.R), 15535);
    run("dmax1", 16'd65535, 16'd1, 0, 0);
    run("d5by7", 16'd5, 16'd7, 0, 0);
    run("dovf", 16'd65535, 16'h8001, 0, 0);
    check("dovf.r", 32'(bus.R), 32766);
    run("dz", 16'd234, 16'd0, 0, 0);
    check("dz.q", 32'(bus.Q), 32'hFFFF);
    run("after_dz", 16'd10, 16'd3, 0, 0);
    check("after_dz.dz", 32'(bus.Div_Zero), 0);
    run("ignore", 16'd1000, 16'd7, 5, 0);
    check("ignore.q", 32'(bus.Q), 142);
    run("abort", 16'd60000, 16'd7, 0, 8);
    check_zero("abort.end");
    run("fresh", 16'd1000, 16'd7, 0, 0);
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = (i % 5 == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom);
      run("rnd", ra, rb, 0, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seq_div_16_bit.md
SEQ_DIV_16_BIT -- requirements
Module: seq_div_16_bit

Interface
REQ-001 The block SHALL have no parameters; all datapaths SHALL be a fixed 16 bits.
REQ-002 clk  input  1  single clock for the block; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request a divide; sampled only in IDLE.
REQ-005 A  input  16  unsigned dividend; sampled when start is accepted.
REQ-006 B  input  16  unsigned divisor; sampled when start is accepted.
REQ-007 busy  output  1  high in RUN and DONE.
REQ-008 done  output  1  one-cycle pulse; Q/R/Div_Zero are valid this cycle.
REQ-009 Q  output  16  quotient.
REQ-010 R  output  16  remainder.
REQ-011 Div_Zero  output  1  set when the accepted B was zero.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1 at edge k, the block SHALL latch A and B, clear the partial remainder, set the iteration counter to 0 and clear Div_Zero.
REQ-014 If B!=0 at edge k, the next state SHALL be RUN.
REQ-015 If B==0 at edge k, the next state SHALL be DONE; at edge k the block SHALL load Q=16'hFFFF, R=A and Div_Zero=1.
REQ-016 Each RUN cycle SHALL perform one restoring step, MSB of the dividend first:
- trial = {R_partial, next dividend bit} - {1'b0, B}, computed 17 bits wide.
- If the trial borrow is 0, the new remainder SHALL be the trial value and the quotient bit SHALL be 1.
- Otherwise the new remainder SHALL be the shifted value and the quotient bit SHALL be 0.
REQ-017 RUN SHALL last exactly 16 cycles (edges k+1..k+16); the counter SHALL be 4 bits and its wrap 15->0 SHALL trigger RUN->DONE at edge k+16.
REQ-018 done SHALL be high only while the state is DONE; DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
- Latency is 17 cycles from the accepting edge to done when B!=0.
- Latency is 1 cycle from the accepting edge to done when B==0.
REQ-019 Q, R and Div_Zero SHALL hold their values from DONE until the next accepted start.
REQ-020 start in RUN or DONE SHALL be ignored, with no effect on the operation in progress and no queuing.
REQ-021 A and B changing after acceptance SHALL NOT affect the result.
REQ-022 For B!=0 the results SHALL satisfy A == Q*B + R and R < B exactly.
REQ-023 The 17-bit trial subtraction SHALL prevent overflow when the partial remainder has bit 15 set, for example when B > 16'h8000.
REQ-024 busy SHALL go high at the accepting edge k and low at the edge leaving DONE.

Reset
REQ-025 While rst_n=0 the block SHALL immediately force state=IDLE, busy=0, done=0, Q=0, R=0, Div_Zero=0 and counter=0, independent of clk.
REQ-026 Reset asserted mid-RUN SHALL abort the operation with no done pulse.
REQ-027 After rst_n deasserts, the first rising edge SHALL be able to accept start.

Verification
REQ-028 The bench SHALL cover these scenarios:
- A=523, B=234, start at edge k -> done at k+17, Q=2, R=55, Div_Zero=0.
- A=40535, B=25000 -> Q=1, R=15535; then A=65535, B=1 -> Q=65535, R=0.
- A=5, B=7 -> Q=0, R=5; and A=65535, B=16'h8001 -> Q=1, R=32766 (overflow path).
- A=234, B=0 -> done at k+1, Q=16'hFFFF, R=234, Div_Zero=1; next divide A=10, B=3 -> Div_Zero=0, Q=3, R=1.
- start pulsed with new operands at k+5 during RUN -> ignored; the original result appears at k+17 and exactly one done pulse occurs.
- rst_n low at k+8 -> outputs 0 immediately, no done pulse; a fresh start after release completes normally.
REQ-029 A random check SHALL run at least 1000 operand pairs against a Q=A/B, R=A%B model, asserting done pulse width=1 and busy/done timing per REQ-018 and REQ-024.
